dft_frame_ctrl: RTL and testbench

DFT_FRAME_CTRL -- requirements
Module: dft_frame_ctrl

---
 rtl/dft_ctrl_pkg.sv | 14 +
 rtl/dft_frame_ctrl.sv | 136 +++++++++++++
 tb/tb_dft_frame_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dft_ctrl_pkg.sv
// Shared definitions for the DFT frame controller: FSM state encoding and
// the default width of the frame-length / point counters.
package dft_ctrl_pkg;

    localparam int unsigned LEN_W_DEF = 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        DRAIN    = 2'd2,
        WAIT_DFT = 2'd3
    } state_t;

endpackage

// File: rtl/dft_frame_ctrl.sv
// DFT frame controller: accepts a frame request, forwards 2*len raw samples
// to the 2:1 averaging stage, counts the averaged points coming back, flags
// the last point to the DFT core and reports completion once the core is done.
module dft_frame_ctrl
    import dft_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    output logic [DATA_W-1:0] pre_data,
    output logic              pre_valid,
    output logic              pre_rst,
    input  logic              pre_out_valid,
    input  logic              dft_ready,
    output logic              dft_start,
    output logic              dft_last,
    input  logic              dft_done,
    output logic              busy,
    output logic              done,
    output logic              err_cfg,
    output logic              err_ovf,
    output logic [LEN_W-1:0]  pt_cnt
);

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W:0]   in_cnt;
    logic [LEN_W:0]   in_cnt_nxt;
    logic [LEN_W-1:0] pt_cnt_nxt;
    logic             in_frame;
    logic             start_ok;
    logic             start_bad;
    logic             sample_take;
    logic             sample_drop;
    logic             pt_take;
    logic             frame_end;
    logic             in_full;

    // Qualified events; abort overrides every other action in its cycle.
    always_comb begin
        in_frame    = (state == RUN) || (state == DRAIN);
        start_ok    = (state == IDLE) && start && !abort && (cfg_len != '0);
        start_bad   = (state == IDLE) && start && !abort && (cfg_len == '0);
        sample_take = (state == RUN) && adc_valid && dft_ready && !abort;
        sample_drop = (state == RUN) && adc_valid && !dft_ready && !abort;
        pt_take     = in_frame && pre_out_valid && (pt_cnt < len_q) && !abort;
        in_cnt_nxt  = in_cnt + 1'b1;
        pt_cnt_nxt  = pt_cnt + 1'b1;
        frame_end   = pt_take && (pt_cnt_nxt == len_q);
        in_full     = sample_take && (in_cnt_nxt == {len_q, 1'b0});
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the last point ends the frame even if input is still filling.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:     if (start_ok) state_nxt = RUN;
                RUN: begin
                    if (frame_end)    state_nxt = WAIT_DFT;
                    else if (in_full) state_nxt = DRAIN;
                end
                DRAIN:    if (frame_end) state_nxt = WAIT_DFT;
                WAIT_DFT: if (dft_done)  state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    // State-decoded outputs.
    always_comb begin
        busy     = (state != IDLE);
        dft_last = in_frame && (pt_cnt == len_q - 1'b1);
    end

    // Frame datapath, counters and registered pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_data  <= '0;
            pre_valid <= 1'b0;
            pre_rst   <= 1'b0;
            dft_start <= 1'b0;
            done      <= 1'b0;
            err_cfg   <= 1'b0;
            err_ovf   <= 1'b0;
            pt_cnt    <= '0;
            len_q     <= '0;
            in_cnt    <= '0;
        end else begin
            pre_valid <= sample_take;
            pre_rst   <= start_ok || abort;
            dft_start <= start_ok;
            err_cfg   <= start_bad;
            done      <= (state == WAIT_DFT) && dft_done && !abort;
            if (sample_take) begin
                pre_data <= adc_data;
            end
            if (start_ok) begin
                len_q   <= cfg_len;
                in_cnt  <= '0;
                pt_cnt  <= '0;
                err_ovf <= 1'b0;
            end else begin
                if (sample_take) begin
                    in_cnt <= in_cnt_nxt;
                end
                if (sample_drop) begin
                    err_ovf <= 1'b1;
                end
                if (pt_take) begin
                    pt_cnt <= pt_cnt_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_dft_frame_ctrl.sv
// Self-checking bench for dft_frame_ctrl: a counter-based frame model is
// compared against the DUT on every cycle, directed frames pin the model
// with literal expectations, and a randomized phase exercises the rest.
module tb_dft_frame_ctrl;

    localparam int DW = 12;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [LW-1:0] cfg_len = '0;
    logic [DW-1:0] adc_data = '0;
    logic          adc_valid = 1'b0;
    logic [DW-1:0] pre_data;
    logic          pre_valid;
    logic          pre_rst;
    logic          pre_out_valid = 1'b0;
    logic          dft_ready = 1'b1;
    logic          dft_start;
    logic          dft_last;
    logic          dft_done = 1'b0;
    logic          busy;
    logic          done;
    logic          err_cfg;
    logic          err_ovf;
    logic [LW-1:0] pt_cnt;

    int errors = 0;
    int checks = 0;

    // DUT event counters (sampled by the compare process)
    int n_fwd = 0, n_done = 0, n_dstart = 0, n_errcfg = 0, n_prerst = 0, n_last = 0;

    // Behavioural frame model
    bit          m_active = 0;
    bit          m_wait = 0;
    int          m_len = 0;
    int          m_in = 0;
    int          m_pt = 0;
    bit          m_ovf = 0;
    bit          e_pre_valid = 0, e_pre_rst = 0, e_dft_start = 0, e_done = 0, e_err_cfg = 0;
    logic [DW-1:0] e_pre_data = '0;

    // Averaging-stage emulation
    bit pair = 0;
    int extra_pct = 0;

    dft_frame_ctrl #(.DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_len(cfg_len),
        .adc_data(adc_data), .adc_valid(adc_valid), .pre_data(pre_data),
        .pre_valid(pre_valid), .pre_rst(pre_rst), .pre_out_valid(pre_out_valid),
        .dft_ready(dft_ready), .dft_start(dft_start), .dft_last(dft_last),
        .dft_done(dft_done), .busy(busy), .done(done), .err_cfg(err_cfg),
        .err_ovf(err_ovf), .pt_cnt(pt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_wait = 0; m_len = 0; m_in = 0; m_pt = 0; m_ovf = 0;
        e_pre_valid = 0; e_pre_rst = 0; e_dft_start = 0; e_done = 0; e_err_cfg = 0;
        e_pre_data = '0;
    endtask

    task automatic model_step();
        e_pre_valid = 0; e_pre_rst = 0; e_dft_start = 0; e_done = 0; e_err_cfg = 0;
        if (abort) begin
            e_pre_rst = 1; m_active = 0; m_wait = 0;
        end else if (!m_active && !m_wait) begin
            if (start) begin
                if (cfg_len == 0) begin
                    e_err_cfg = 1;
                end else begin
                    m_active = 1; m_len = int'(cfg_len); m_in = 0; m_pt = 0; m_ovf = 0;
                    e_pre_rst = 1; e_dft_start = 1;
                end
            end
        end else if (m_wait) begin
            if (dft_done) begin
                e_done = 1; m_wait = 0;
            end
        end else begin
            if (adc_valid && m_in < 2 * m_len) begin
                if (dft_ready) begin
                    m_in++; e_pre_valid = 1; e_pre_data = adc_data;
                end else begin
                    m_ovf = 1;
                end
            end
            if (pre_out_valid && m_pt < m_len) begin
                m_pt++;
                if (m_pt == m_len) begin
                    m_active = 0; m_wait = 1;
                end
            end
        end
    endtask

    // Reference model advance on every clock (reset is asynchronous)
    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // Per-cycle comparison of all DUT outputs against the model
    always @(negedge clk) begin
        chk("busy",      busy,      32'(m_active || m_wait));
        chk("pt_cnt",    pt_cnt,    m_pt);
        chk("dft_last",  dft_last,  32'(m_active && (m_pt == m_len - 1)));
        chk("err_ovf",   err_ovf,   m_ovf);
        chk("pre_valid", pre_valid, e_pre_valid);
        chk("pre_data",  pre_data,  e_pre_data);
        chk("pre_rst",   pre_rst,   e_pre_rst);
        chk("dft_start", dft_start, e_dft_start);
        chk("done",      done,      e_done);
        chk("err_cfg",   err_cfg,   e_err_cfg);
        if (pre_valid === 1'b1) n_fwd++;
        if (done === 1'b1)      n_done++;
        if (dft_start === 1'b1) n_dstart++;
        if (err_cfg === 1'b1)   n_errcfg++;
        if (pre_rst === 1'b1)   n_prerst++;
        if (dft_last === 1'b1)  n_last++;
    end

    // Set inputs for the next rising edge; pre_out_valid follows every second
    // forwarded sample, with pairing cleared by pre_rst.
    task automatic drive(input bit s, input bit a, input int len, input bit av,
                         input bit rdy, input bit dd);
        bit strobe;
        @(negedge clk);
        strobe = 0;
        if (rst || pre_rst) begin
            pair = 0;
        end else if (pre_valid) begin
            strobe = pair;
            pair = !pair;
        end
        start = s; abort = a; cfg_len = LW'(len);
        adc_valid = av; adc_data = DW'($urandom); dft_ready = rdy; dft_done = dd;
        pre_out_valid = strobe || ($urandom_range(99) < extra_pct);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 1, 0);
    endtask

    // Start a frame with continuous samples; ready drops for two cycles at gap_at.
    task automatic run_frame(input int len, input int gap_at, input string tag);
        bit ok;
        ok = 0;
        drive(1, 0, len, 1, 1, 0);
        for (int i = 0; i < 40; i++) begin
            drive(0, 0, 0, 1, !(i == gap_at || i == gap_at + 1), 0);
            if (pt_cnt == LW'(len)) begin
                ok = 1;
                break;
            end
        end
        chk({tag, "_reach_len"}, ok, 1);
    endtask

    initial begin
        int b_fwd, b_done, b_dstart, b_errcfg, b_prerst, b_last;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_pt_cnt", pt_cnt, 0);
        chk("rst_pre_valid", pre_valid, 0);
        rst = 1'b0;
        idle(2);

        // Nominal frame of 4 points
        b_fwd = n_fwd; b_done = n_done; b_dstart = n_dstart; b_last = n_last;
        run_frame(4, -5, "nom");
        drive(0, 0, 0, 0, 1, 1);
        idle(3);
        chk("nom_fwd", n_fwd - b_fwd, 8);
        chk("nom_done", n_done - b_done, 1);
        chk("nom_dstart", n_dstart - b_dstart, 1);
        chk("nom_last_cycles", n_last - b_last, 2);
        chk("nom_pt_final", pt_cnt, 4);
        chk("nom_busy_end", busy, 0);

        // Zero length request
        b_errcfg = n_errcfg; b_dstart = n_dstart;
        drive(1, 0, 0, 0, 1, 0);
        idle(3);
        chk("zero_errcfg", n_errcfg - b_errcfg, 1);
        chk("zero_dstart", n_dstart - b_dstart, 0);
        chk("zero_busy", busy, 0);

        // Back-pressure during RUN
        b_fwd = n_fwd; b_done = n_done;
        run_frame(4, 2, "ovf");
        chk("ovf_sticky", err_ovf, 1);
        drive(0, 0, 0, 0, 1, 1);
        idle(3);
        chk("ovf_fwd", n_fwd - b_fwd, 8);
        chk("ovf_done", n_done - b_done, 1);
        chk("ovf_still_set", err_ovf, 1);

        // Abort after three samples, then a clean frame
        b_fwd = n_fwd; b_done = n_done; b_prerst = n_prerst;
        drive(1, 0, 4, 0, 1, 0);
        repeat (3) drive(0, 0, 0, 1, 1, 0);
        drive(0, 1, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 1);
        idle(3);
        chk("abort_fwd", n_fwd - b_fwd, 3);
        chk("abort_done", n_done - b_done, 0);
        chk("abort_prerst", n_prerst - b_prerst, 2);
        chk("abort_busy", busy, 0);
        b_fwd = n_fwd; b_done = n_done;
        run_frame(4, -5, "clean");
        chk("clean_ovf", err_ovf, 0);
        drive(0, 0, 0, 0, 1, 1);
        idle(3);
        chk("clean_fwd", n_fwd - b_fwd, 8);
        chk("clean_done", n_done - b_done, 1);

        // Start and abort together
        b_dstart = n_dstart; b_prerst = n_prerst;
        drive(1, 1, 4, 0, 1, 0);
        idle(3);
        chk("both_dstart", n_dstart - b_dstart, 0);
        chk("both_prerst", n_prerst - b_prerst, 1);
        chk("both_busy", busy, 0);

        // Asynchronous reset while waiting for the DFT core
        run_frame(4, 1, "wrst");
        idle(1);
        chk("wrst_busy_pre", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("wrst_busy", busy, 0);
        chk("wrst_pt_cnt", pt_cnt, 0);
        chk("wrst_err_ovf", err_ovf, 0);
        chk("wrst_pre_data", pre_data, 0);
        chk("wrst_outs", {pre_valid, pre_rst, dft_start, done, err_cfg, dft_last}, 0);
        @(negedge clk);
        rst = 1'b0;
        b_done = n_done;
        drive(0, 0, 0, 0, 1, 1);
        idle(3);
        chk("wrst_no_done", n_done - b_done, 0);

        // Randomized traffic, including stray point strobes
        extra_pct = 5;
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(7) == 0, $urandom_range(39) == 0, $urandom_range(5),
                  $urandom_range(3) != 0, $urandom_range(7) != 0, $urandom_range(5) == 0);
        end
        extra_pct = 0;
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
